alu_multicycle: RTL
===================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal range 8..64).
REQ-002 SHALL have parameter MUL_EN, default 1, enables the iterative multiply opcode when 1.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset: synchronous, active-low.
REQ-005 SHALL have port in_valid_i, input, 1 bit, operand/opcode present.
REQ-006 SHALL have port in_ready_o, output, 1 bit, block can accept an operation.
REQ-007 SHALL have port src1_i, input, WIDTH bits, first operand.
REQ-008 SHALL have port src2_i, input, WIDTH bits, second operand.
REQ-009 SHALL have port op_i, input, 4 bits, opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR, 1000 MUL (unsigned, low WIDTH bits), 0011 SLL (src1 << src2[log2 WIDTH-1:0]), 0100 SRA.
REQ-010 SHALL have port out_valid_o, output, 1 bit, result registers hold a completed result.
REQ-011 SHALL have port out_ready_i, input, 1 bit, consumer takes result.
REQ-012 SHALL have port result_o, output, WIDTH bits, registered result.
REQ-013 SHALL have port zero_o, output, 1 bit, 1 when result_o is all zeros.
REQ-014 SHALL have port overflow_o, output, 1 bit, signed overflow for ADD/SUB; for MUL, any nonzero bit above WIDTH-1 of the full product; 0 otherwise.
REQ-015 SHALL have port busy_o, output, 1 bit, 1 while a MUL iterates.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, DONE; in_ready_o = 1 only in IDLE.
REQ-017 SHALL accept an operation on an edge with in_valid_i & in_ready_o; operands and opcode are captured then and ignored afterwards.
REQ-018 SHALL, for non-MUL opcodes, go IDLE->DONE with result registered at the accepting edge: out_valid_o high the following cycle (latency 1).
REQ-019 SHALL, for MUL with MUL_EN=1, go IDLE->MUL, perform one shift-add step per cycle for exactly WIDTH cycles, then enter DONE (out_valid_o high WIDTH+1 cycles after acceptance).
REQ-020 SHALL hold result_o, zero_o, overflow_o and out_valid_o stable in DONE until out_valid_o & out_ready_i; that edge returns to IDLE.
REQ-021 SHALL not accept a new operation in the same cycle a result is consumed (in_ready_o rises the cycle after DONE exits).
REQ-022 SHALL compute ADD/SUB modulo 2^WIDTH; SLT returns 1 in bit 0 when src1 < src2 signed, including when src1-src2 overflows.
REQ-023 SHALL treat an undefined opcode, or MUL with MUL_EN=0, as latency-1 with result 0, zero_o 1, overflow_o 0.
REQ-024 SHALL ignore in_valid_i outside IDLE and ignore out_ready_i outside DONE.
REQ-025 SHALL drive zero_o and overflow_o from registers updated together with result_o.

Reset
REQ-026 SHALL, on rising edge with rst_n low, enter IDLE and clear result_o=0, overflow_o=0, out_valid_o=0, busy_o=0; zero_o=1; in_ready_o=1 after reset deasserts.
REQ-027 SHALL abort an in-progress MUL or pending DONE result on reset with no output produced.

Structure
REQ-028 SHALL place opcode constants and the FSM state encoding in a shared package alu_pkg.
REQ-029 SHALL isolate single-cycle operations in one sub-module alu_comb (WIDTH-parametrised, purely combinational, result/overflow outputs).
REQ-030 SHALL use a WIDTH-bit multiplicand, WIDTH-bit multiplier shift register, 2*WIDTH-bit accumulator and a log2(WIDTH)+1-bit step counter for MUL.

Verification
REQ-031 SHALL test ADD 0x7FFFFFFF + 0x00000001 (WIDTH=32) -> one cycle later result 0x80000000, overflow_o 1, zero_o 0.
REQ-032 SHALL test SUB 5 - 5 -> result 0, zero_o 1, overflow_o 0; SLT 0x80000000 vs 0x00000001 -> result 1.
REQ-033 SHALL test MUL 0x00010000 * 0x00010000 -> busy_o high 32 cycles, out_valid_o on cycle 33, result 0, overflow_o 1; MUL 7*6 -> result 42, overflow_o 0.
REQ-034 SHALL test backpressure: out_ready_i held 0 for 10 cycles in DONE -> result_o stable, in_ready_o 0, new in_valid_i ignored.
REQ-035 SHALL test reset mid-MUL at step 10 -> next cycle IDLE, out_valid_o 0, result_o 0, zero_o 1, no result emitted.
REQ-036 SHALL test SRA 0xF0000000 by 4 -> 0xFF000000; undefined opcode 1111 -> result 0, zero_o 1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM states shared by the multicycle ALU
package alu_pkg;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRA = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle ALU operations; MUL and unknown opcodes yield zero
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_overflow
);
  localparam int SW = $clog2(WIDTH);
  logic [WIDTH-1:0] w_sum, w_diff, w_sra, w_slt;
  logic [SW-1:0]    w_sh;
  logic             w_add_ovf, w_sub_ovf;
  assign w_sh      = i_b[SW-1:0];
  assign w_sum     = i_a + i_b;
  assign w_diff    = i_a - i_b;
  // kept apart so the arithmetic shift and signed compare stay signed
  assign w_sra     = $signed(i_a) >>> w_sh;
  assign w_slt     = WIDTH'($signed(i_a) < $signed(i_b));
  assign w_add_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
  assign w_sub_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
  always_comb begin
    o_result   = i_op == OP_AND ? i_a & i_b :
                 i_op == OP_OR  ? i_a | i_b :
                 i_op == OP_ADD ? w_sum :
                 i_op == OP_SUB ? w_diff :
                 i_op == OP_SLT ? w_slt :
                 i_op == OP_NOR ? ~(i_a | i_b) :
                 i_op == OP_SLL ? i_a << w_sh :
                 i_op == OP_SRA ? w_sra : '0;
    o_overflow = i_op == OP_ADD ? w_add_ovf :
                 i_op == OP_SUB ? w_sub_ovf : 1'b0;
  end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: valid/ready ALU with latency-1 ops and an iterative shift-add multiply
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             busy_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand, r_mplier, r_result;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_zero, r_ovf;
  logic [WIDTH-1:0]   w_comb_res;
  logic               w_comb_ovf, w_is_mul;
  logic [2*WIDTH-1:0] w_addend, w_acc_nxt;
  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .i_a       (src1_i),
    .i_b       (src2_i),
    .i_op      (op_i),
    .o_result  (w_comb_res),
    .o_overflow(w_comb_ovf)
  );
  assign w_is_mul  = MUL_EN && op_i == OP_MUL;
  // partial product for the current multiplier bit, weighted by the step number
  assign w_addend  = {{WIDTH{1'b0}}, {WIDTH{r_mplier[0]}} & r_mcand} << r_cnt;
  assign w_acc_nxt = r_acc + w_addend;
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid_i) begin
          if (w_is_mul) begin
            r_state  <= S_MUL;
            r_mcand  <= src1_i;
            r_mplier <= src2_i;
            r_acc    <= '0;
            r_cnt    <= '0;
          end else begin
            r_state  <= S_DONE;
            r_result <= w_comb_res;
            r_zero   <= w_comb_res == '0;
            r_ovf    <= w_comb_ovf;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state  <= S_DONE;
            r_result <= w_acc_nxt[WIDTH-1:0];
            r_zero   <= w_acc_nxt[WIDTH-1:0] == '0;
            r_ovf    <= |w_acc_nxt[2*WIDTH-1:WIDTH];
          end
        end
        S_DONE: if (out_ready_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign in_ready_o  = r_state == S_IDLE;
  assign out_valid_o = r_state == S_DONE;
  assign busy_o      = r_state == S_MUL;
  assign result_o    = r_result;
  assign zero_o      = r_zero;
  assign overflow_o  = r_ovf;
endmodule
